// File: rtl/router_pkg.sv
// Shared types and header field layout for the router ingress block.
package router_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned NUM_PORTS_DEF = 3;

  // Header byte layout: destination address in the low bits, payload length above it
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LFD,
    ST_HDR_WR,
    ST_PAYLOAD,
    ST_PARITY,
    ST_CHECK,
    ST_DROP
  } state_t;

endpackage

// File: rtl/router_ingress_parity.sv
// Running XOR accumulator over header and payload, compared against the parity byte.
module router_ingress_parity
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              update,
  input  logic              compare,
  input  logic [DATA_W-1:0] load_val,
  input  logic [DATA_W-1:0] din,
  output logic              mismatch
);

  logic [DATA_W-1:0] acc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc      <= '0;
      mismatch <= 1'b0;
    end else begin
      if (load) begin
        acc <= load_val;
      end else if (update) begin
        acc <= acc ^ din;
      end
      if (compare) begin
        mismatch <= (acc != din);
      end
    end
  end

endmodule

// File: rtl/router_ingress.sv
// Packet ingress FSM: steers header/payload/parity bytes to one of NUM_PORTS FIFOs.
// Parity checking is built only when ROUTER_INGRESS_PARITY_EN is defined.
module router_ingress
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [DATA_W-1:0]    dout,
  output logic                 err,
  output logic                 pkt_done
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [ADDR_W-1:0] port_q, port_d;
  logic [LEN_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] in_addr;
  logic [LEN_W-1:0]  in_len;
  logic [LEN_W-1:0]  hdr_len;
  logic              addr_ok;
  logic              port_full;
  logic              accept;
  logic              hdr_fire;
  logic              pay_fire;
  logic              par_fire;

  assign in_addr   = data_in[ADDR_MSB:ADDR_LSB];
  assign in_len    = data_in[LEN_MSB:LEN_LSB];
  assign hdr_len   = hdr_q[LEN_MSB:LEN_LSB];
  assign addr_ok   = (32'(in_addr) < NUM_PORTS);
  assign port_full = fifo_full[port_q];
  assign accept    = pkt_valid && !busy;

  // Header write stalls while the target FIFO is full so a strobe never meets a full flag
  assign hdr_fire  = (state_q == ST_HDR_WR) && !port_full;
  assign pay_fire  = (state_q == ST_PAYLOAD) && accept;
  assign par_fire  = (state_q == ST_PARITY) && accept;

`ifdef ROUTER_INGRESS_PARITY_EN
  logic acc_mismatch;

  router_ingress_parity #(
    .DATA_W (DATA_W)
  ) u_parity (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_q == ST_CHECK),
    .load     (hdr_fire),
    .update   (pay_fire),
    .compare  (par_fire),
    .load_val (hdr_q),
    .din      (data_in),
    .mismatch (acc_mismatch)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      port_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      port_q  <= port_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    port_d    = port_q;
    count_d   = count_q;
    busy      = 1'b0;
    write_enb = '0;
    lfd_state = 1'b0;
    dout      = '0;
    err       = 1'b0;
    pkt_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          if (addr_ok) begin
            hdr_d   = data_in;
            port_d  = in_addr;
            state_d = ST_LFD;
          end else begin
            // count holds bytes still to discard after the current one
            count_d = in_len;
            state_d = ST_DROP;
          end
        end
      end

      ST_LFD: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        if (!port_full) begin
          state_d = ST_HDR_WR;
        end
      end

      ST_HDR_WR: begin
        busy = 1'b1;
        if (hdr_fire) begin
          write_enb[port_q] = 1'b1;
          dout              = hdr_q;
          count_d           = hdr_len;
          state_d           = (hdr_len == '0) ? ST_PARITY : ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        busy = port_full;
        if (pay_fire) begin
          write_enb[port_q] = 1'b1;
          dout              = data_in;
          count_d           = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        busy = port_full;
        if (par_fire) begin
          write_enb[port_q] = 1'b1;
          dout              = data_in;
          state_d           = ST_CHECK;
        end
      end

      ST_CHECK: begin
        busy     = 1'b1;
        pkt_done = 1'b1;
`ifdef ROUTER_INGRESS_PARITY_EN
        err      = acc_mismatch;
`endif
        state_d  = ST_IDLE;
      end

      ST_DROP: begin
        if (pkt_valid) begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            count_d = count_q - LEN_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_ingress.sv
// Self-checking bench for router_ingress: directed packets plus randomized traffic
// scored against a byte-stream model of expected FIFO writes and end-of-packet results.
module tb_router_ingress;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 3;
`ifdef ROUTER_INGRESS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic [NP-1:0] fifo_full;
  logic          busy;
  logic [NP-1:0] write_enb;
  logic          lfd_state;
  logic [DW-1:0] dout;
  logic          err;
  logic          pkt_done;

  router_ingress #(.DATA_W(DW), .NUM_PORTS(NP)) dut (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .fifo_full (fifo_full),
    .busy      (busy),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .dout      (dout),
    .err       (err),
    .pkt_done  (pkt_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       port;
    logic [7:0] b;
    bit       hdr;
  } wr_t;

  wr_t        exp_q[$];
  bit         done_q[$];
  wr_t        mon_e;
  logic [7:0] pl_buf[64];
  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;
  bit         mon_en = 1'b0;
  bit         rand_full = 1'b0;
  bit         lfd_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [NP-1:0] pick_full();
    if (rand_full && $urandom_range(0, 2) == 0) return NP'($urandom_range(1, 7));
    return '0;
  endfunction

  // Expected FIFO traffic for one packet, straight from the packet format rules
  task automatic model_packet(input logic [7:0] hdr, input logic [7:0] par);
    int         len;
    int         addr;
    logic [7:0] x;
    wr_t        e;
    len  = int'(hdr[7:2]);
    addr = int'(hdr[1:0]);
    x    = hdr;
    if (addr < int'(NP)) begin
      e.port = addr; e.b = hdr; e.hdr = 1'b1;
      exp_q.push_back(e);
      e.hdr = 1'b0;
      for (int i = 0; i < len; i++) begin
        e.b = pl_buf[i];
        x   = x ^ pl_buf[i];
        exp_q.push_back(e);
      end
      e.b = par;
      exp_q.push_back(e);
      done_q.push_back(PAR_EN && (x != par));
    end
  endtask

  // Present one byte until the DUT takes it; returns at posedge+1 after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit took;
    n = 0;
    pkt_valid = 1'b1;
    data_in   = b;
    forever begin
      fifo_full = pick_full();
      #1;
      took = !busy;
      @(posedge clock); #1;
      if (took) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 32'(0), 32'(1));
        break;
      end
    end
    pkt_valid = 1'b0;
    data_in   = 8'($urandom);
    if (rand_full && $urandom_range(0, 3) == 0) begin
      fifo_full = pick_full();
      @(posedge clock); #1;
    end
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input bit lfd_chk);
    int len;
    len = int'(hdr[7:2]);
    model_packet(hdr, par);
    send_byte(hdr);
    if (lfd_chk) begin
      #1;
      chk("lfd_cycle_lfd", 32'(lfd_state), 32'(1));
      chk("lfd_cycle_wr", 32'(write_enb), 32'(0));
      chk("lfd_cycle_busy", 32'(busy), 32'(1));
      @(posedge clock); #1;
      chk("hdr_cycle_lfd", 32'(lfd_state), 32'(0));
      chk("hdr_cycle_wr", 32'(write_enb), 32'(1 << int'(hdr[1:0])));
      chk("hdr_cycle_dout", 32'(dout), 32'(hdr));
    end
    for (int i = 0; i < len; i++) send_byte(pl_buf[i]);
    send_byte(par);
  endtask

  task automatic drain(input string tag);
    fifo_full = '0;
    pkt_valid = 1'b0;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || done_q.size() != 0); n++) begin
      @(posedge clock); #1;
    end
    repeat (2) @(posedge clock);
    #1;
    chk(tag, 32'(exp_q.size() + done_q.size()), 32'(0));
  endtask

  // Monitor: every strobe and pulse must match the model stream
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (lfd_state) begin
        lfd_seen = 1'b1;
        chk("lfd_no_wr", 32'(write_enb), 32'(0));
      end
      if (write_enb != '0) begin
        chk("wr_onehot", 32'($onehot(write_enb)), 32'(1));
        chk("wr_while_full", 32'(write_enb & fifo_full), 32'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(write_enb), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_port", 32'(write_enb), 32'(1 << mon_e.port));
          chk("wr_dout", 32'(dout), 32'(mon_e.b));
          if (mon_e.hdr) begin
            chk("hdr_after_lfd", 32'(lfd_seen), 32'(1));
            lfd_seen = 1'b0;
          end
        end
      end else begin
        chk("dout_idle", 32'(dout), 32'(0));
      end
      if (pkt_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
        else chk("err_at_done", 32'(err), 32'(done_q.pop_front()));
      end else begin
        chk("err_no_done", 32'(err), 32'(0));
      end
    end
  end

  initial begin
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] x;
    int         len;
    wr_t        e;

    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = '0;
    fifo_full = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr", 32'(write_enb), 32'(0));
    chk("rst_lfd", 32'(lfd_state), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_done", 32'(pkt_done), 32'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Good packet to port 1, LEN 3
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    send_packet(8'h0D, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33, 1'b1);
    drain("good_pkt_drain");

    // Same packet, corrupted parity byte
    send_packet(8'h0D, 8'hFF, 1'b0);
    drain("bad_parity_drain");

    // Backpressure on port 0 mid-payload
    pl_buf[0] = 8'hA5; pl_buf[1] = 8'h5A;
    model_packet(8'h08, 8'h08 ^ 8'hA5 ^ 8'h5A);
    send_byte(8'h08);
    send_byte(8'hA5);
    pkt_valid = 1'b1;
    data_in   = 8'h5A;
    fifo_full = NP'(1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_busy", 32'(busy), 32'(1));
      chk("full_no_wr", 32'(write_enb), 32'(0));
      @(posedge clock); #1;
    end
    fifo_full = '0;
    send_byte(8'h5A);
    send_byte(8'h08 ^ 8'hA5 ^ 8'h5A);
    drain("backpressure_drain");

    // Unroutable address 3: header plus two bytes dropped, then a normal packet
    pl_buf[0] = 8'h99;
    send_packet(8'h07, 8'h66, 1'b0);
    chk("drop_busy", 32'(busy), 32'(0));
    pl_buf[0] = 8'h3C;
    send_packet(8'h05, 8'h05 ^ 8'h3C, 1'b1);
    drain("after_drop_drain");

    // Reset after the second payload byte of a LEN 5 packet
    e.port = 1; e.hdr = 1'b1; e.b = 8'h15; exp_q.push_back(e);
    e.hdr = 1'b0; e.b = 8'hC1; exp_q.push_back(e);
    e.b = 8'hC2; exp_q.push_back(e);
    send_byte(8'h15);
    send_byte(8'hC1);
    send_byte(8'hC2);
    chk("pre_reset_writes", 32'(exp_q.size()), 32'(0));
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    lfd_seen = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_wr", 32'(write_enb), 32'(0));
    chk("mid_rst_lfd", 32'(lfd_state), 32'(0));
    chk("mid_rst_dout", 32'(dout), 32'(0));
    chk("mid_rst_pulses", 32'({err, pkt_done}), 32'(0));
    @(posedge clock); #1;
    send_packet(8'h02, 8'h02, 1'b1);
    drain("post_reset_drain");

    // Randomized traffic with random backpressure and idle gaps
    rand_full = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 12);
      hdr = {6'(len), 2'($urandom_range(0, 3))};
      x   = hdr;
      for (int i = 0; i < len; i++) begin
        pl_buf[i] = 8'($urandom);
        x = x ^ pl_buf[i];
      end
      par = ($urandom_range(0, 1) == 1) ? x : 8'($urandom);
      send_packet(hdr, par, 1'b0);
    end
    rand_full = 1'b0;
    drain("random_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
